spi_rx_monitor: RTL and testbench

//  Receive-side SPI capture stage, downstream of the SPI master. Samples the master's SCK/MOSI/BUSY
//  in the CLK_48MHZ domain, deserialises MSB-first bytes (mode 0: sample on SCK rising edge),
//  and buffers them in a small FIFO for a consumer such as a UART dump or self-check logic.

---
 rtl/spi_rx_monitor_pkg.sv | 17 +
 rtl/spi_rx_monitor_sync_fifo.sv | 57 +++++
 rtl/spi_rx_monitor.sv | 166 ++++++++++++++++
 tb/tb_spi_rx_monitor.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_monitor_pkg.sv
// rtl/spi_rx_monitor_pkg.sv - shared SPI constants and FSM state encoding for spi_rx_monitor
// Contents:
//   SPI_CPOL/SPI_CPHA  SPI mode 0 (idle-low clock, sample on rising edge)
//   DEFAULT_DATA_W     default SPI word width
//   state_t            receive FSM states (ST_IDLE=0, ST_SHIFT=1)
package spi_rx_monitor_pkg;

    localparam int SPI_CPOL       = 0;
    localparam int SPI_CPHA       = 0;
    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_rx_monitor_sync_fifo.sv
// rtl/spi_rx_monitor_sync_fifo.sv - single-clock FIFO buffering received SPI words
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (storage cleared too)
//   wr_en        push request; accepted when not full, or when full with a pop in the same cycle
//   wr_data      word to push
//   rd_en        pop request; ignored when empty
//   rd_data      head word, read combinationally from storage
//   full, empty  occupancy status
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    // Extra MSB distinguishes full from empty when the index bits match.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_rd;
    logic              do_wr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/spi_rx_monitor.sv
// rtl/spi_rx_monitor.sv - SPI mode-0 receive monitor: synchronise, deserialise, buffer, report frame status
// Ports:
//   CLK_48MHZ, NSYSRESET   system clock, asynchronous active-low reset
//   SCK, MOSI, FRAME       asynchronous SPI pins from the master (FRAME = master BUSY)
//   RD_EN                  consumer pop, ignored when RX_EMPTY
//   CLR_ERR                clears OVERFLOW and FRAME_ERR; a simultaneous set wins
//   RX_DATA                FIFO head word, valid while !RX_EMPTY
//   RX_EMPTY, RX_FULL      FIFO status
//   WORD_CNT               words completed in the current/last frame, saturating
//   FRAME_DONE             one-cycle pulse when a frame ends
//   FRAME_ERR              sticky: frame ended with a partial word pending
//   OVERFLOW               sticky: a completed word was dropped on a full FIFO
module spi_rx_monitor
    import spi_rx_monitor_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 8
) (
    input  logic              CLK_48MHZ,
    input  logic              NSYSRESET,
    input  logic              SCK,
    input  logic              MOSI,
    input  logic              FRAME,
    input  logic              RD_EN,
    input  logic              CLR_ERR,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_EMPTY,
    output logic              RX_FULL,
    output logic [CNT_W-1:0]  WORD_CNT,
    output logic              FRAME_DONE,
    output logic              FRAME_ERR,
    output logic              OVERFLOW
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] frame_sync;
    // Marks when the synchroniser outputs reflect real pin samples after reset.
    logic [SYNC_STAGES-1:0] prime_sr;
    logic                   sck_d;
    logic                   frame_d;
    logic                   armed;

    logic sck_s, mosi_s, frame_s, primed;
    logic sck_rise, frame_rise, frame_fall;

    state_t            state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  word_cnt;
    logic              word_done;
    logic              frame_done;
    logic              frame_err;
    logic              overflow;
    logic              err_set;
    logic              ovf_set;
    logic              fifo_full;

    assign sck_s      = sck_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign frame_s    = frame_sync[SYNC_STAGES-1];
    assign primed     = prime_sr[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_d;
    assign frame_rise = frame_s & ~frame_d;
    assign frame_fall = ~frame_s & frame_d;

    always_ff @(posedge CLK_48MHZ or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            sck_sync   <= '0;
            mosi_sync  <= '0;
            frame_sync <= '0;
            prime_sr   <= '0;
            sck_d      <= 1'b0;
            frame_d    <= 1'b0;
            armed      <= 1'b0;
        end else begin
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], SCK};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            frame_sync <= {frame_sync[SYNC_STAGES-2:0], FRAME};
            prime_sr   <= {prime_sr[SYNC_STAGES-2:0], 1'b1};
            sck_d      <= sck_s;
            frame_d    <= frame_s;
            // FRAME must be seen low after reset before a rise may start a frame;
            // otherwise a FRAME already high at release would look like a new rise.
            armed      <= armed | (primed & ~frame_s);
        end
    end

    assign err_set = (state == ST_SHIFT) && frame_fall && (bit_cnt != '0);
    // With a full FIFO, RD_EN implies a real pop, so the push is accepted.
    assign ovf_set = word_done && fifo_full && !RD_EN;

    always_ff @(posedge CLK_48MHZ or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            word_cnt   <= '0;
            word_done  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            word_done  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= err_set | (frame_err & ~CLR_ERR);
            overflow   <= ovf_set | (overflow & ~CLR_ERR);
            // Count in the push cycle so WORD_CNT and FIFO occupancy move together.
            if (word_done && (word_cnt != {CNT_W{1'b1}})) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (frame_rise && armed) begin
                        state     <= ST_SHIFT;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        word_cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    // Frame end takes priority over a coincident SCK rise.
                    if (frame_fall) begin
                        frame_done <= 1'b1;
                        bit_cnt    <= '0;
                        state      <= ST_IDLE;
                    end else if (sck_rise) begin
                        shift_reg <= {shift_reg[DATA_W-2:0], mosi_s};
                        if (bit_cnt == BIT_W'(DATA_W-1)) begin
                            bit_cnt   <= '0;
                            word_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK_48MHZ),
        .rst_n   (NSYSRESET),
        .wr_en   (word_done),
        .wr_data (shift_reg),
        .rd_en   (RD_EN),
        .rd_data (RX_DATA),
        .full    (fifo_full),
        .empty   (RX_EMPTY)
    );

    assign RX_FULL    = fifo_full;
    assign WORD_CNT   = word_cnt;
    assign FRAME_DONE = frame_done;
    assign FRAME_ERR  = frame_err;
    assign OVERFLOW   = overflow;

endmodule

// File: tb/tb_spi_rx_monitor.sv
// tb/tb_spi_rx_monitor.sv - self-checking bench for spi_rx_monitor
module tb_spi_rx_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       frame = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_full;
    logic [7:0] word_cnt;
    logic       frame_done;
    logic       frame_err;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    spi_rx_monitor dut (
        .CLK_48MHZ  (clk),
        .NSYSRESET  (rst_n),
        .SCK        (sck),
        .MOSI       (mosi),
        .FRAME      (frame),
        .RD_EN      (rd_en),
        .CLR_ERR    (clr_err),
        .RX_DATA    (rx_data),
        .RX_EMPTY   (rx_empty),
        .RX_FULL    (rx_full),
        .WORD_CNT   (word_cnt),
        .FRAME_DONE (frame_done),
        .FRAME_ERR  (frame_err),
        .OVERFLOW   (overflow)
    );

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [39:0] bits;
        int          nbits;
        int          exp_cnt;
        logic        exp_err;
        logic        exp_ovf;
        int          exp_n;
        logic [31:0] exp_w;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, input int hi, input int lo);
        mosi = b;
        repeat (lo) @(negedge clk);
        sck = 1'b1;
        repeat (hi) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_frame(input logic [39:0] bits, input int nbits, input int hi, input int lo);
        @(negedge clk);
        frame = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) spi_bit(bits[i], hi, lo);
        repeat (lo) @(negedge clk);
        frame = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check({name, "_nonempty"}, 32'(rx_empty), 32'd0);
        check(name, 32'(rx_data), 32'(exp));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && rx_empty == 1'b0; i++) begin
            rd_en = 1'b1;
            @(negedge clk);
        end
        rd_en = 1'b0;
        check("drain_empty", 32'(rx_empty), 32'd1);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0]  q[$];
    logic        m_err;
    logic        m_ovf;
    int          m_cnt;
    int          d0;

    initial begin
        vecs[0] = '{40'h000000A53C, 16, 2, 1'b0, 1'b0, 2, 32'hA53C0000};
        vecs[1] = '{40'h0000000F0A, 12, 1, 1'b1, 1'b0, 1, 32'hF0000000};
        vecs[2] = '{40'h0102030405, 40, 5, 1'b0, 1'b1, 4, 32'h01020304};
        vecs[3] = '{40'h0000000081,  8, 1, 1'b0, 1'b0, 1, 32'h81000000};
        vecs[4] = '{40'h0000000005,  3, 0, 1'b1, 1'b0, 0, 32'h00000000};

        repeat (3) @(negedge clk);
        check("rst_empty", 32'(rx_empty), 32'd1);
        check("rst_full", 32'(rx_full), 32'd0);
        check("rst_cnt", 32'(word_cnt), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            drain();
            pulse_clr();
            d0 = done_cnt;
            send_frame(vecs[v].bits, vecs[v].nbits, 3, 3);
            check($sformatf("v%0d_done", v), 32'(done_cnt - d0), 32'd1);
            check($sformatf("v%0d_cnt", v), 32'(word_cnt), 32'(vecs[v].exp_cnt));
            check($sformatf("v%0d_err", v), 32'(frame_err), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_ovf", v), 32'(overflow), 32'(vecs[v].exp_ovf));
            check($sformatf("v%0d_full", v), 32'(rx_full), 32'(vecs[v].exp_n == 4));
            for (int k = 0; k < vecs[v].exp_n; k++)
                pop_check($sformatf("v%0d_w%0d", v, k), vecs[v].exp_w[31-8*k -: 8]);
            check($sformatf("v%0d_empty", v), 32'(rx_empty), 32'd1);
            pulse_clr();
            check($sformatf("v%0d_clr_err", v), 32'(frame_err), 32'd0);
            check($sformatf("v%0d_clr_ovf", v), 32'(overflow), 32'd0);
        end

        // Full FIFO with a pop in the exact cycle the fifth word is pushed
        drain();
        pulse_clr();
        @(negedge clk);
        frame = 1'b1;
        repeat (4) @(negedge clk);
        begin
            logic [39:0] b5;
            b5 = 40'h0102030405;
            for (int i = 39; i >= 1; i--) spi_bit(b5[i], 3, 3);
            mosi = b5[0];
        end
        repeat (3) @(negedge clk);
        sck = 1'b1;                 // pin rise; capture after 3 edges, push one later
        repeat (3) @(negedge clk);
        check("hold_full", 32'(rx_full), 32'd1);
        check("hold_head", 32'(rx_data), 32'h01);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        sck = 1'b0;
        repeat (3) @(negedge clk);
        frame = 1'b0;
        repeat (8) @(negedge clk);
        check("hold_ovf", 32'(overflow), 32'd0);
        check("hold_cnt", 32'(word_cnt), 32'd5);
        check("hold_full2", 32'(rx_full), 32'd1);
        for (int k = 2; k <= 5; k++) pop_check($sformatf("hold_w%0d", k), 8'(k));

        // SCK activity outside a frame
        d0 = done_cnt;
        for (int i = 0; i < 16; i++) spi_bit(i[0], 3, 3);
        repeat (8) @(negedge clk);
        check("idle_empty", 32'(rx_empty), 32'd1);
        check("idle_cnt", 32'(word_cnt), 32'd5);
        check("idle_done", 32'(done_cnt - d0), 32'd0);

        // Reset in the middle of a frame, with data and a flag pending
        send_frame(40'h77, 8, 3, 3);
        send_frame(40'h5, 3, 3, 3);
        check("pre_rst_err", 32'(frame_err), 32'd1);
        @(negedge clk);
        frame = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 3, 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_empty", 32'(rx_empty), 32'd1);
        check("mid_rst_cnt", 32'(word_cnt), 32'd0);
        check("mid_rst_err", 32'(frame_err), 32'd0);
        check("mid_rst_data", 32'(rx_data), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;               // FRAME still high: must not start a frame
        repeat (6) @(negedge clk);
        d0 = done_cnt;
        for (int i = 7; i >= 0; i--) spi_bit(i == 7 || i == 0, 3, 3);
        repeat (3) @(negedge clk);
        frame = 1'b0;
        repeat (8) @(negedge clk);
        check("stale_empty", 32'(rx_empty), 32'd1);
        check("stale_done", 32'(done_cnt - d0), 32'd0);
        check("stale_cnt", 32'(word_cnt), 32'd0);
        send_frame(40'h81, 8, 3, 3);
        check("post_rst_cnt", 32'(word_cnt), 32'd1);
        check("post_rst_err", 32'(frame_err), 32'd0);
        pop_check("post_rst_w", 8'h81);

        // Counter saturation: 256 words in one frame at the fastest SCK
        @(negedge clk);
        frame = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 256 * 8; i++) spi_bit(1'b0, 2, 2);
        repeat (2) @(negedge clk);
        frame = 1'b0;
        repeat (8) @(negedge clk);
        check("sat_cnt", 32'(word_cnt), 32'd255);
        check("sat_ovf", 32'(overflow), 32'd1);
        check("sat_err", 32'(frame_err), 32'd0);
        drain();
        pulse_clr();

        // Randomised frames against a queue-based reference model
        q.delete();
        m_err = 1'b0;
        m_ovf = 1'b0;
        for (int f = 0; f < 30; f++) begin
            logic [39:0] bits;
            int nbits, hi, lo, nw, k;
            bits  = 40'({$urandom(), $urandom()});
            nbits = int'($urandom_range(1, 40));
            hi    = int'($urandom_range(2, 4));
            lo    = int'($urandom_range(2, 4));
            nw    = nbits / 8;
            for (int j = 0; j < nw; j++) begin
                logic [7:0] w;
                w = 8'((bits >> (nbits - 8 * (j + 1))) & 40'hFF);
                if (q.size() == 4) m_ovf = 1'b1;
                else q.push_back(w);
            end
            if (nbits % 8 != 0) m_err = 1'b1;
            m_cnt = nw;
            d0 = done_cnt;
            send_frame(bits, nbits, hi, lo);
            check($sformatf("r%0d_done", f), 32'(done_cnt - d0), 32'd1);
            check($sformatf("r%0d_cnt", f), 32'(word_cnt), 32'(m_cnt));
            check($sformatf("r%0d_err", f), 32'(frame_err), 32'(m_err));
            check($sformatf("r%0d_ovf", f), 32'(overflow), 32'(m_ovf));
            check($sformatf("r%0d_full", f), 32'(rx_full), 32'(q.size() == 4));
            check($sformatf("r%0d_empty", f), 32'(rx_empty), 32'(q.size() == 0));
            k = int'($urandom_range(0, q.size()));
            for (int j = 0; j < k; j++) begin
                pop_check($sformatf("r%0d_pop%0d", f, j), q[0]);
                void'(q.pop_front());
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr();
                m_err = 1'b0;
                m_ovf = 1'b0;
                check($sformatf("r%0d_clr", f), 32'({frame_err, overflow}), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
